// File: rtl/drone_motor_pkg.sv
// Shared types and sizing for the quad-motor arm sequencer.
package drone_motor_pkg;

    localparam int unsigned NUM_MOTORS = 4;
    localparam int unsigned DUTY_W     = 11;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/motor_slew_limiter.sv
// Per-motor duty register driven toward its target.
// SLEW_LIMIT_EN defined: bounded step per control tick; undefined: duty follows target next cycle.
module motor_slew_limiter
    import drone_motor_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 5
) (
    input  logic  clock,
    input  logic  reset,
    input  duty_t target,
    input  logic  tick,
    input  logic  clear,
    output duty_t duty
);

`ifdef SLEW_LIMIT_EN
    localparam logic signed [DUTY_W:0] STEP   = $signed((DUTY_W+1)'(SLEW_STEP));
    localparam duty_t                  STEP_D = duty_t'(SLEW_STEP);

    // One extra bit keeps target-duty signed without wrapping at either end.
    logic signed [DUTY_W:0] diff;
    assign diff = $signed({1'b0, target}) - $signed({1'b0, duty});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty <= '0;
        end else if (clear) begin
            duty <= '0;
        end else if (tick) begin
            if (diff > STEP) begin
                duty <= duty + STEP_D;
            end else if (diff < -STEP) begin
                duty <= duty - STEP_D;
            end else begin
                duty <= target;
            end
        end
    end
`else
    logic unused_tick;
    assign unused_tick = tick;
    localparam int unsigned unused_step = SLEW_STEP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty <= '0;
        end else if (clear) begin
            duty <= '0;
        end else begin
            duty <= target;
        end
    end
`endif

endmodule

// File: rtl/drone_motor_arm_sequencer.sv
// ESC arming FSM, control-tick prescaler, command watchdog and per-motor duty limiters.
// Build option SLEW_LIMIT_EN selects tick-based slew limiting inside motor_slew_limiter.
module drone_motor_arm_sequencer
    import drone_motor_pkg::*;
#(
    parameter int unsigned DUTY_MAX   = 1000,
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned ARM_TICKS  = 2000,
    parameter int unsigned WDOG_TICKS = 100,
    parameter int unsigned SLEW_STEP  = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cmd_valid,
    input  logic [NUM_MOTORS*DUTY_W-1:0] cmd_throttle,
    input  logic                         arm_req,
    input  logic                         disarm_req,
    output logic [NUM_MOTORS*DUTY_W-1:0] motor_duty,
    output logic                         pwm_en,
    output logic                         armed,
    output logic                         failsafe,
    output logic [1:0]                   state
);

    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ARM_W  = $clog2(ARM_TICKS + 1);
    localparam int unsigned WDOG_W = $clog2(WDOG_TICKS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TICKS - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_TICKS - 1);
    localparam duty_t             DUTY_CAP  = duty_t'(DUTY_MAX);

    seq_state_e        state_q, state_d;
    logic [PRE_W-1:0]  presc_q;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              failsafe_d;
    logic              tick;
    logic              tgt_load, tgt_zero, duty_clr;
    logic              cmd_all_zero, duty_all_zero;
    duty_t             target_q [NUM_MOTORS];
    duty_t             duty_w   [NUM_MOTORS];

    assign tick          = (presc_q == PRE_LAST);
    assign cmd_all_zero  = (cmd_throttle == '0);
    assign duty_all_zero = (motor_duty == '0);
    assign state         = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        wdog_d     = wdog_q;
        failsafe_d = failsafe;
        tgt_load   = 1'b0;
        tgt_zero   = 1'b0;
        duty_clr   = 1'b0;
        if (disarm_req) begin
            state_d  = DISARMED;
            tgt_zero = 1'b1;
            duty_clr = 1'b1;
        end else begin
            case (state_q)
                DISARMED: begin
                    duty_clr = 1'b1;
                    if (arm_req && cmd_all_zero) begin
                        state_d    = ARMING;
                        arm_cnt_d  = '0;
                        failsafe_d = 1'b0;
                    end
                end
                ARMING: begin
                    duty_clr = 1'b1;
                    if (tick) begin
                        if (arm_cnt_q == ARM_LAST) begin
                            state_d  = ARMED;
                            tgt_zero = 1'b1;
                            wdog_d   = '0;
                        end else begin
                            arm_cnt_d = arm_cnt_q + ARM_W'(1);
                        end
                    end
                end
                ARMED: begin
                    // A command in the same cycle as a tick feeds the watchdog.
                    if (cmd_valid) begin
                        tgt_load = 1'b1;
                        wdog_d   = '0;
                    end else if (tick) begin
                        if (wdog_q == WDOG_LAST) begin
                            state_d    = FAILSAFE;
                            failsafe_d = 1'b1;
                            tgt_zero   = 1'b1;
                        end else begin
                            wdog_d = wdog_q + WDOG_W'(1);
                        end
                    end
                end
                FAILSAFE: begin
                    tgt_zero = 1'b1;
                    if (duty_all_zero) begin
                        state_d = DISARMED;
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= DISARMED;
            arm_cnt_q <= '0;
            wdog_q    <= '0;
            failsafe  <= 1'b0;
            pwm_en    <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
            wdog_q    <= wdog_d;
            failsafe  <= failsafe_d;
            pwm_en    <= (state_d != DISARMED);
            armed     <= (state_d == ARMED);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) target_q[m] <= '0;
        end else if (tgt_zero) begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) target_q[m] <= '0;
        end else if (tgt_load) begin
            for (int unsigned m = 0; m < NUM_MOTORS; m++) begin
                if (cmd_throttle[m*DUTY_W +: DUTY_W] > DUTY_CAP) begin
                    target_q[m] <= DUTY_CAP;
                end else begin
                    target_q[m] <= cmd_throttle[m*DUTY_W +: DUTY_W];
                end
            end
        end
    end

    for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_motor
        motor_slew_limiter #(
            .SLEW_STEP(SLEW_STEP)
        ) u_limiter (
            .clock (clock),
            .reset (reset),
            .target(target_q[m]),
            .tick  (tick),
            .clear (duty_clr),
            .duty  (duty_w[m])
        );
        assign motor_duty[m*DUTY_W +: DUTY_W] = duty_w[m];
    end

endmodule

// File: tb/tb_drone_motor_arm_sequencer.sv
// Directed self-checking bench for drone_motor_arm_sequencer; expectations follow SLEW_LIMIT_EN.
module tb_drone_motor_arm_sequencer;
    import drone_motor_pkg::*;

    localparam int unsigned TICK_DIV   = 10;
    localparam int unsigned ARM_TICKS  = 4;
    localparam int unsigned WDOG_TICKS = 3;
    localparam int unsigned SLEW_STEP  = 5;
    localparam int unsigned DUTY_MAX   = 1000;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         cmd_valid = 1'b0;
    logic                         arm_req = 1'b0;
    logic                         disarm_req = 1'b0;
    logic [NUM_MOTORS*DUTY_W-1:0] cmd_throttle = '0;
    logic [NUM_MOTORS*DUTY_W-1:0] motor_duty;
    logic                         pwm_en, armed, failsafe;
    logic [1:0]                   state;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned edge_n = 0;

    always #5 clock = ~clock;

    drone_motor_arm_sequencer #(
        .DUTY_MAX  (DUTY_MAX),
        .TICK_DIV  (TICK_DIV),
        .ARM_TICKS (ARM_TICKS),
        .WDOG_TICKS(WDOG_TICKS),
        .SLEW_STEP (SLEW_STEP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_throttle(cmd_throttle),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .motor_duty  (motor_duty),
        .pwm_en      (pwm_en),
        .armed       (armed),
        .failsafe    (failsafe),
        .state       (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int unsigned m);
        return 32'(motor_duty[m*DUTY_W +: DUTY_W]);
    endfunction

    // Expected duty k ticks after a command toward tgt was accepted.
    function automatic logic [31:0] ramp(input int unsigned k, input int unsigned tgt);
`ifdef SLEW_LIMIT_EN
        return (k * SLEW_STEP < tgt) ? k * SLEW_STEP : tgt;
`else
        return tgt;
`endif
    endfunction

    // Tick takes effect on every TICK_DIV-th edge after reset release.
    task automatic cyc();
        @(posedge clock);
        edge_n++;
        #1;
    endtask

    task automatic to_tick();
        do cyc(); while (edge_n % TICK_DIV != 0);
    endtask

    task automatic set_cmd(input int unsigned l0, input int unsigned l1,
                           input int unsigned l2, input int unsigned l3);
        cmd_throttle = {DUTY_W'(l3), DUTY_W'(l2), DUTY_W'(l1), DUTY_W'(l0)};
    endtask

    task automatic send_at_tick(input int unsigned l0, input int unsigned l1);
        while (edge_n % TICK_DIV != TICK_DIV - 1) cyc();
        set_cmd(l0, l1, 0, 0);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0);
    endtask

    task automatic arm_and_wait(input string tag);
        arm_req = 1'b1;
        cyc();
        arm_req = 1'b0;
        check({tag, "_arming_state"}, state, 1);
        check({tag, "_arming_pwm"}, pwm_en, 1);
        for (int t = 1; t <= ARM_TICKS; t++) begin
            to_tick();
            if (t == 2) begin
                arm_req = 1'b1;
                cyc();
                arm_req = 1'b0;
            end
            if (t < ARM_TICKS) begin
                check($sformatf("%s_arming_t%0d", tag, t), state, 1);
                check($sformatf("%s_arming_armed_t%0d", tag, t), armed, 0);
            end else begin
                check({tag, "_armed_state"}, state, 2);
                check({tag, "_armed_flag"}, armed, 1);
            end
        end
        check({tag, "_armed_duty0"}, lane(0), 0);
    endtask

    initial begin
        set_cmd(0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        edge_n = 0;
        check("rst_state", state, 0);
        check("rst_pwm", pwm_en, 0);
        check("rst_armed", armed, 0);
        check("rst_failsafe", failsafe, 0);
        check("rst_duty", motor_duty, 0);
        repeat (3) cyc();
        check("idle_state", state, 0);

        set_cmd(0, 0, 7, 0);
        arm_req = 1'b1;
        cyc();
        arm_req = 1'b0;
        set_cmd(0, 0, 0, 0);
        check("arm_nz_state", state, 0);
        check("arm_nz_pwm", pwm_en, 0);

        arm_and_wait("arm1");

        for (int k = 0; k <= 201; k++) begin
            send_at_tick(100, 2000);
            if (k == 0) check("ramp_k0", lane(0), 0);
            if (k == 1 || k == 2 || k == 20 || k == 21)
                check($sformatf("ramp0_k%0d", k), lane(0), ramp(k, 100));
            if (k == 1 || k == 200 || k == 201)
                check($sformatf("ramp1_k%0d", k), lane(1), ramp(k, DUTY_MAX));
        end
        check("ramp_state", state, 2);

        send_at_tick(0, 0);
        to_tick();
`ifdef SLEW_LIMIT_EN
        check("down_duty0", lane(0), 95);
`else
        check("down_duty0", lane(0), 0);
`endif
        disarm_req = 1'b1;
        arm_req = 1'b1;
        cyc();
        disarm_req = 1'b0;
        arm_req = 1'b0;
        check("disarm_state", state, 0);
        check("disarm_pwm", pwm_en, 0);
        check("disarm_duty", motor_duty, 0);
        repeat (3) cyc();
        check("disarm_hold_state", state, 0);

        arm_and_wait("arm2");
        for (int k = 0; k <= 4; k++) send_at_tick(20, 0);
        check("wd_duty20", lane(0), 20);
        for (int t = 1; t <= 2; t++) begin
            to_tick();
            check($sformatf("wd_state_t%0d", t), state, 2);
            check($sformatf("wd_fs_t%0d", t), failsafe, 0);
        end
        to_tick();
        check("fs_state", state, 3);
        check("fs_flag", failsafe, 1);
        check("fs_armed", armed, 0);
        check("fs_pwm", pwm_en, 1);
        check("fs_duty_entry", lane(0), 20);
`ifdef SLEW_LIMIT_EN
        for (int v = 15; v >= 0; v -= 5) begin
            to_tick();
            check($sformatf("fs_ramp_%0d", v), lane(0), v);
            check($sformatf("fs_ramp_state_%0d", v), state, 3);
        end
`else
        cyc();
        check("fs_zero_duty", lane(0), 0);
        check("fs_zero_state", state, 3);
`endif
        cyc();
        check("fs_done_state", state, 0);
        check("fs_done_pwm", pwm_en, 0);
        check("fs_sticky", failsafe, 1);

        arm_req = 1'b1;
        cyc();
        arm_req = 1'b0;
        check("rearm_state", state, 1);
        check("rearm_fs_clear", failsafe, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
